// File: rtl/tl45_wb_arbiter.sv
// Two-master to one-slave Wishbone arbiter: whole-cycle grants, round-robin on
// contention, and a no-ack watchdog that aborts a hung cycle with ERR.
module tl45_wb_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  input  logic        i_m0_we,
  input  logic [29:0] i_m0_addr,
  input  logic [31:0] i_m0_data,
  input  logic [3:0]  i_m0_sel,
  output logic        o_m0_ack,
  output logic        o_m0_stall,
  output logic        o_m0_err,
  output logic [31:0] o_m0_data,
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  input  logic        i_m1_we,
  input  logic [29:0] i_m1_addr,
  input  logic [31:0] i_m1_data,
  input  logic [3:0]  i_m1_sel,
  output logic        o_m1_ack,
  output logic        o_m1_stall,
  output logic        o_m1_err,
  output logic [31:0] o_m1_data,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [29:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, ABORT} state_t;

  state_t           state;
  logic             last_grant;
  logic [CNT_W-1:0] count;
  logic             own_cyc;
  logic             other_cyc;

  always_comb begin
    own_cyc   = 1'b0;
    other_cyc = 1'b0;
    if (state == GRANT0) begin
      own_cyc   = i_m0_cyc;
      other_cyc = i_m1_cyc;
    end else if (state == GRANT1) begin
      own_cyc   = i_m1_cyc;
      other_cyc = i_m0_cyc;
    end
  end

  // last_grant doubles as the identity of the aborted master while in ABORT.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (i_m0_cyc && (!i_m1_cyc || last_grant)) begin
            state      <= GRANT0;
            last_grant <= 1'b0;
          end else if (i_m1_cyc) begin
            state      <= GRANT1;
            last_grant <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          if (!own_cyc) begin
            count <= '0;
            if (other_cyc) begin
              state      <= (state == GRANT0) ? GRANT1 : GRANT0;
              last_grant <= (state == GRANT0);
            end else begin
              state <= IDLE;
            end
          end else if (i_wb_ack || i_wb_err) begin
            count <= '0;
          end else if (count == CNT_W'(TIMEOUT - 1)) begin
            count <= '0;
            state <= ABORT;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: begin
          count <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    o_wb_cyc   = 1'b0;
    o_wb_stb   = 1'b0;
    o_wb_we    = 1'b0;
    o_wb_addr  = '0;
    o_wb_data  = '0;
    o_wb_sel   = '0;
    o_m0_ack   = 1'b0;
    o_m0_err   = 1'b0;
    o_m0_stall = 1'b1;
    o_m1_ack   = 1'b0;
    o_m1_err   = 1'b0;
    o_m1_stall = 1'b1;
    case (state)
      GRANT0: begin
        o_wb_cyc   = i_m0_cyc;
        o_wb_stb   = i_m0_stb;
        o_wb_we    = i_m0_we;
        o_wb_addr  = i_m0_addr;
        o_wb_data  = i_m0_data;
        o_wb_sel   = i_m0_sel;
        o_m0_ack   = i_wb_ack;
        o_m0_err   = i_wb_err;
        o_m0_stall = i_wb_stall;
      end
      GRANT1: begin
        o_wb_cyc   = i_m1_cyc;
        o_wb_stb   = i_m1_stb;
        o_wb_we    = i_m1_we;
        o_wb_addr  = i_m1_addr;
        o_wb_data  = i_m1_data;
        o_wb_sel   = i_m1_sel;
        o_m1_ack   = i_wb_ack;
        o_m1_err   = i_wb_err;
        o_m1_stall = i_wb_stall;
      end
      ABORT: begin
        if (last_grant) o_m1_err = 1'b1;
        else            o_m0_err = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_m0_data = i_wb_data;
  assign o_m1_data = i_wb_data;

endmodule
